// File: rtl/mem_lsu_if.sv
// Bundle of the MEM-stage request/response handshake and the data-memory port.
// master = the load/store unit, slave = the datapath plus memory that surround it.
interface mem_lsu_if #(
  parameter int ADDR_W = 8
) ();
  logic              Req_Valid;
  logic              Req_Ready;
  logic              Req_Write;
  logic [1:0]        Req_Size;
  logic              Req_Signed;
  logic [ADDR_W-1:0] Req_Addr;
  logic [31:0]       Req_WData;
  logic              Resp_Valid;
  logic              Resp_Err;
  logic [31:0]       Resp_RData;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Read;
  logic              Mem_Write;
  logic [31:0]       M_W_Data;
  logic [31:0]       M_R_Data;

  modport master (
    input  Req_Valid, Req_Write, Req_Size, Req_Signed, Req_Addr, Req_WData, M_R_Data,
    output Req_Ready, Resp_Valid, Resp_Err, Resp_RData, Mem_Addr, Mem_Read, Mem_Write, M_W_Data
  );

  modport slave (
    output Req_Valid, Req_Write, Req_Size, Req_Signed, Req_Addr, Req_WData, M_R_Data,
    input  Req_Ready, Resp_Valid, Resp_Err, Resp_RData, Mem_Addr, Mem_Read, Mem_Write, M_W_Data
  );
endinterface

// File: rtl/mem_lsu.sv
// Single-request load/store unit for a word-wide, little-endian data memory.
// Sub-word stores go through a read-modify-write because the memory only writes whole words.
module mem_lsu #(
  parameter int ADDR_W              = 8,
  parameter bit ZERO_RDATA_ON_STORE = 1'b1
) (
  input logic       CLK,
  input logic       Reset,
  mem_lsu_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_CAPT,
    RMW_RD,
    RMW_MERGE,
    ST_WR,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  state_t            state_q, state_d;
  logic              wr_q, sgn_q, err_q;
  size_t             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;

  logic              req_err;
  logic [ADDR_W-1:0] aligned_addr;
  logic [31:0]       load_ext, merged;

  assign req_err = (bus.Req_Size == SZ_ILL)
                 | ((bus.Req_Size == SZ_HALF) & bus.Req_Addr[0])
                 | ((bus.Req_Size == SZ_WORD) & (bus.Req_Addr[1:0] != 2'b00));

  assign aligned_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Lane selection for loads: byte lane addr[1:0], half lane addr[1].
  always_comb begin : lane_extract
    logic [7:0]  b;
    logic [15:0] h;
    b = bus.M_R_Data[{addr_q[1:0], 3'b000} +: 8];
    h = addr_q[1] ? bus.M_R_Data[31:16] : bus.M_R_Data[15:0];
    case (size_q)
      SZ_BYTE: load_ext = {{24{sgn_q & b[7]}}, b};
      SZ_HALF: load_ext = {{16{sgn_q & h[15]}}, h};
      default: load_ext = bus.M_R_Data;
    endcase
  end

  // Only byte and half stores reach RMW_MERGE, so anything not a byte is a half.
  always_comb begin : store_merge
    merged = bus.M_R_Data;
    if (size_q == SZ_BYTE) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // NOTE: state and data registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.Req_Valid) begin
        wr_q    <= bus.Req_Write;
        sgn_q   <= bus.Req_Signed;
        err_q   <= req_err;
        size_q  <= size_t'(bus.Req_Size);
        addr_q  <= bus.Req_Addr;
        wdata_q <= bus.Req_WData;
      end
      if (state_q == LD_CAPT)   rdata_q <= load_ext;
      // The request data is no longer needed once merged, so the merged word reuses its register.
      if (state_q == RMW_MERGE) wdata_q <= merged;
    end
  end

  // NOTE: every output and state_d gets a default before the case, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    bus.Req_Ready  = 1'b0;
    bus.Mem_Read   = 1'b0;
    bus.Mem_Write  = 1'b0;
    bus.Mem_Addr   = '0;
    bus.M_W_Data   = '0;
    bus.Resp_Valid = 1'b0;
    bus.Resp_Err   = 1'b0;
    bus.Resp_RData = '0;
    case (state_q)
      IDLE: begin
        bus.Req_Ready = 1'b1;
        if (bus.Req_Valid) begin
          if (req_err)                     state_d = RESP;
          else if (!bus.Req_Write)         state_d = LD_ISSUE;
          else if (bus.Req_Size == SZ_WORD) state_d = ST_WR;
          else                             state_d = RMW_RD;
        end
      end
      LD_ISSUE: begin
        bus.Mem_Read = 1'b1;
        bus.Mem_Addr = aligned_addr;
        state_d      = LD_CAPT;
      end
      LD_CAPT: state_d = RESP;
      RMW_RD: begin
        bus.Mem_Read = 1'b1;
        bus.Mem_Addr = aligned_addr;
        state_d      = RMW_MERGE;
      end
      RMW_MERGE: state_d = ST_WR;
      ST_WR: begin
        bus.Mem_Write = 1'b1;
        bus.Mem_Addr  = aligned_addr;
        bus.M_W_Data  = wdata_q;
        state_d       = RESP;
      end
      RESP: begin
        bus.Resp_Valid = 1'b1;
        bus.Resp_Err   = err_q;
        bus.Resp_RData = (ZERO_RDATA_ON_STORE && (wr_q || err_q)) ? 32'd0 : rdata_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios followed by random requests,
// all judged against a byte-array reference memory with arithmetic extraction.
module tb_mem_lsu;
  localparam int ADDR_W = 8;

  logic CLK   = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  mem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  mem_lsu #(.ADDR_W(ADDR_W), .ZERO_RDATA_ON_STORE(1'b1)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Word-wide memory attached to the DUT port, plus activity counters.
  logic [31:0] dmem [64];
  bit          mem_ready = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;

  // Independent reference: a plain byte array.
  logic [7:0] ref_mem [256];

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
      bus.M_R_Data <= '0;
      mem_ready    <= 1'b1;
    end else begin
      if (bus.Mem_Write) begin
        dmem[bus.Mem_Addr[7:2]] <= bus.M_W_Data;
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.Mem_Read) begin
        bus.M_R_Data <= dmem[bus.Mem_Addr[7:2]];
        rd_cnt <= rd_cnt + 1;
      end
      if (bus.Mem_Read && bus.Mem_Write) both_cnt <= both_cnt + 1;
      if (bus.Resp_Valid) resp_cnt <= resp_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit ref_err(logic [1:0] sz, logic [7:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_word(logic [7:0] a);
    int base;
    base = int'(a) - int'(a) % 4;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  function automatic logic [31:0] ref_load(logic [1:0] sz, bit sg, logic [7:0] a);
    int v;
    case (sz)
      2'd0: begin
        v = int'(ref_mem[a]);
        if (sg && v >= 128) v -= 256;
        return 32'(v);
      end
      2'd1: begin
        v = int'(ref_mem[a]) + 256 * int'(ref_mem[int'(a) + 1]);
        if (sg && v >= 32768) v -= 65536;
        return 32'(v);
      end
      default: return ref_word(a);
    endcase
  endfunction

  task automatic ref_store(logic [1:0] sz, logic [7:0] a, logic [31:0] wd);
    int n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
  endtask

  // One complete request: wait for ready, issue, follow to the response, check everything.
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg, input logic [7:0] a,
                        input logic [31:0] wd, input string tag,
                        output logic [31:0] got_rdata, output logic [31:0] got_wdata);
    bit          e;
    int          n, lat, exp_lat, rd0, wr0, exp_rd_n, exp_wr_n;
    logic [31:0] exp_rd, exp_word;
    got_wdata = '0;
    n = 0;
    while (!bus.Req_Ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "/ready"}, 32'(bus.Req_Ready), 32'd1);

    e        = ref_err(sz, a);
    exp_rd   = '0;
    exp_word = '0;
    exp_rd_n = 0;
    exp_wr_n = 0;
    if (e) begin
      exp_lat = 1;
    end else if (!wr) begin
      exp_lat  = 3;
      exp_rd   = ref_load(sz, sg, a);
      exp_rd_n = 1;
    end else begin
      ref_store(sz, a, wd);
      exp_word = ref_word(a);
      exp_wr_n = 1;
      exp_rd_n = (sz == 2'd2) ? 0 : 1;
      exp_lat  = (sz == 2'd2) ? 2 : 4;
    end
    rd0 = rd_cnt;
    wr0 = wr_cnt;

    bus.Req_Valid  = 1'b1;
    bus.Req_Write  = wr;
    bus.Req_Size   = sz;
    bus.Req_Signed = sg;
    bus.Req_Addr   = a;
    bus.Req_WData  = wd;
    step();
    bus.Req_Valid = 1'b0;

    lat = 1;
    while (!bus.Resp_Valid && lat < 12) begin
      if (bus.Mem_Read || bus.Mem_Write)
        check({tag, "/mem_addr"}, 32'(bus.Mem_Addr), 32'({a[7:2], 2'b00}));
      if (bus.Mem_Write) begin
        got_wdata = bus.M_W_Data;
        check({tag, "/m_w_data"}, bus.M_W_Data, exp_word);
      end
      step();
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/resp_valid"}, 32'(bus.Resp_Valid), 32'd1);
    check({tag, "/resp_err"}, 32'(bus.Resp_Err), 32'(e));
    check({tag, "/resp_rdata"}, bus.Resp_RData, exp_rd);
    check({tag, "/reads"}, 32'(rd_cnt - rd0), 32'(exp_rd_n));
    check({tag, "/writes"}, 32'(wr_cnt - wr0), 32'(exp_wr_n));
    got_rdata = bus.Resp_RData;
    step();
    check({tag, "/resp_one_cycle"}, 32'(bus.Resp_Valid), 32'd0);
  endtask

  // Sub-word load table on word 0x80FF7F01 at 0x20.
  logic [7:0]  ld_addr [5] = '{8'h21, 8'h22, 8'h23, 8'h22, 8'h22};
  logic [1:0]  ld_size [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
  bit          ld_sgn  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] ld_exp  [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                               32'hFFFF_80FF, 32'h0000_80FF};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, wdo, w;
    int          wr0, resp0;

    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
    end
    bus.Req_Valid  = 1'b0;
    bus.Req_Write  = 1'b0;
    bus.Req_Size   = 2'd0;
    bus.Req_Signed = 1'b0;
    bus.Req_Addr   = '0;
    bus.Req_WData  = '0;

    // Reset values
    Reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst/req_ready", 32'(bus.Req_Ready), 32'd1);
    check("rst/resp_valid", 32'(bus.Resp_Valid), 32'd0);
    check("rst/resp_err", 32'(bus.Resp_Err), 32'd0);
    check("rst/mem_read", 32'(bus.Mem_Read), 32'd0);
    check("rst/mem_write", 32'(bus.Mem_Write), 32'd0);
    check("rst/mem_addr", 32'(bus.Mem_Addr), 32'd0);
    check("rst/m_w_data", bus.M_W_Data, 32'd0);
    check("rst/resp_rdata", bus.Resp_RData, 32'd0);
    Reset = 1'b1;
    step();

    // Word store then word load
    do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF, "sw10", rd, wdo);
    check("sw10/wdata_const", wdo, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, "lw10", rd, wdo);
    check("lw10/rdata_const", rd, 32'hDEAD_BEEF);

    // Byte store with read-modify-write
    do_req(1'b1, 2'd2, 1'b0, 8'h20, 32'h1122_3344, "sw20", rd, wdo);
    do_req(1'b1, 2'd0, 1'b0, 8'h22, 32'h0000_00AA, "sb22", rd, wdo);
    check("sb22/merged_const", wdo, 32'h11AA_3344);

    // Sub-word loads with sign/zero extension
    do_req(1'b1, 2'd2, 1'b0, 8'h20, 32'h80FF_7F01, "sw20b", rd, wdo);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, ld_size[i], ld_sgn[i], ld_addr[i], 32'h0, $sformatf("subld%0d", i), rd, wdo);
      check($sformatf("subld%0d/const", i), rd, ld_exp[i]);
    end

    // Misaligned and illegal sizes
    do_req(1'b0, 2'd1, 1'b1, 8'h31, 32'h0, "err_half31", rd, wdo);
    do_req(1'b1, 2'd2, 1'b0, 8'h32, 32'hCAFE_F00D, "err_word32", rd, wdo);
    do_req(1'b0, 2'd3, 1'b0, 8'h00, 32'h0, "err_size3", rd, wdo);

    // Reset asserted during RMW_MERGE of a byte store
    bus.Req_Valid  = 1'b1;
    bus.Req_Write  = 1'b1;
    bus.Req_Size   = 2'd0;
    bus.Req_Signed = 1'b0;
    bus.Req_Addr   = 8'h45;
    bus.Req_WData  = 32'h0000_0055;
    step();
    bus.Req_Valid = 1'b0;
    check("rstmid/rmw_rd_read", 32'(bus.Mem_Read), 32'd1);
    step();
    wr0   = wr_cnt;
    resp0 = resp_cnt;
    Reset = 1'b0;
    #1;
    check("rstmid/req_ready", 32'(bus.Req_Ready), 32'd1);
    check("rstmid/mem_write", 32'(bus.Mem_Write), 32'd0);
    check("rstmid/mem_read", 32'(bus.Mem_Read), 32'd0);
    check("rstmid/m_w_data", bus.M_W_Data, 32'd0);
    step();
    step();
    Reset = 1'b1;
    step();
    step();
    check("rstmid/ready_after", 32'(bus.Req_Ready), 32'd1);
    check("rstmid/no_write", 32'(wr_cnt - wr0), 32'd0);
    check("rstmid/no_resp", 32'(resp_cnt - resp0), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 8'h44, 32'h0, "rstmid_lw44", rd, wdo);

    // Back-to-back with Req_Valid held through a load
    bus.Req_Valid  = 1'b1;
    bus.Req_Write  = 1'b0;
    bus.Req_Size   = 2'd2;
    bus.Req_Signed = 1'b0;
    bus.Req_Addr   = 8'h10;
    step();
    bus.Req_Size = 2'd1;
    bus.Req_Addr = 8'h22;
    check("b2b/busy1_ready", 32'(bus.Req_Ready), 32'd0);
    step();
    check("b2b/busy2_ready", 32'(bus.Req_Ready), 32'd0);
    step();
    check("b2b/a_resp_valid", 32'(bus.Resp_Valid), 32'd1);
    check("b2b/a_rdata", bus.Resp_RData, ref_load(2'd2, 1'b0, 8'h10));
    check("b2b/a_ready_in_resp", 32'(bus.Req_Ready), 32'd0);
    step();
    check("b2b/idle_ready", 32'(bus.Req_Ready), 32'd1);
    step();
    bus.Req_Valid = 1'b0;
    check("b2b/b_accepted", 32'(bus.Req_Ready), 32'd0);
    check("b2b/b_mem_read", 32'(bus.Mem_Read), 32'd1);
    step();
    step();
    check("b2b/b_resp_valid", 32'(bus.Resp_Valid), 32'd1);
    check("b2b/b_rdata", bus.Resp_RData, ref_load(2'd1, 1'b0, 8'h22));
    step();

    // Random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), $urandom, $sformatf("rnd%0d", i), rd, wdo);
    end

    // Final memory image and exclusivity of read/write strobes
    for (int i = 0; i < 64; i++)
      check($sformatf("mem_word%0d", i), dmem[i], ref_word(8'(4 * i)));
    check("read_write_exclusive", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
